// File: rtl/logic_unit_pkg.sv
// Shared types and helpers for the pipelined logic unit.
package logic_unit_pkg;

   typedef enum logic [2:0] {
      OP_AND  = 3'd0,
      OP_OR   = 3'd1,
      OP_XOR  = 3'd2,
      OP_NOR  = 3'd3,
      OP_SLL  = 3'd4,
      OP_SRL  = 3'd5,
      OP_ROL  = 3'd6,
      OP_ANDN = 3'd7
   } op_t;

   // Number of B bits that form the shift amount for a given operand width.
   function automatic int shw_of(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/logic_core.sv
// Combinational logic/shift datapath; all results truncated to WIDTH bits.
module logic_core
   import logic_unit_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  op_t              op,
   output logic [WIDTH-1:0] y
);

   localparam int SHW = shw_of(WIDTH);

   logic [SHW-1:0]     sh;
   logic [2*WIDTH-1:0] rot_dbl;

   assign sh = b[SHW-1:0];
   // Rotating a doubled copy leaves the wrapped bits in the upper half.
   assign rot_dbl = {a, a} << sh;

   always_comb begin
      y = '0;
      unique case (op)
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         OP_XOR:  y = a ^ b;
         OP_NOR:  y = ~(a | b);
         OP_SLL:  y = a << sh;
         OP_SRL:  y = a >> sh;
         OP_ROL:  y = rot_dbl[2*WIDTH-1:WIDTH];
         OP_ANDN: y = a & ~b;
         default: y = '0;
      endcase
   end

endmodule

// File: rtl/logic_unit_pipe.sv
// Logic unit with a single-entry registered output, accumulator and op counter.
module logic_unit_pipe
   import logic_unit_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   input  logic             use_acc,
   input  logic             acc_wr,
   input  logic             acc_clr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             parity,
   output logic             msb,
   output logic [WIDTH-1:0] acc,
   output logic [CNT_W-1:0] op_count
);

   logic [WIDTH-1:0] a_eff_p0;
   logic [WIDTH-1:0] res_p0;
   logic             accept_p0;

   logic [WIDTH-1:0] res_p1;
   logic             vld_p1;
   logic             zero_p1;
   logic             parity_p1;
   logic             msb_p1;
   logic [WIDTH-1:0] acc_q;
   logic [CNT_W-1:0] cnt_q;

   // Stage p0: operand select and combinational op
   assign in_ready  = !vld_p1 || out_ready;
   assign accept_p0 = in_valid && in_ready;
   assign a_eff_p0  = use_acc ? acc_q : a;

   logic_core #(.WIDTH(WIDTH)) u_core (
      .a  (a_eff_p0),
      .b  (b),
      .op (op_t'(op)),
      .y  (res_p0)
   );

   // Stage p1: result register, flags, accumulator and counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_p1    <= '0;
         vld_p1    <= 1'b0;
         zero_p1   <= 1'b0;
         parity_p1 <= 1'b0;
         msb_p1    <= 1'b0;
         cnt_q     <= '0;
      end else if (accept_p0) begin
         res_p1    <= res_p0;
         vld_p1    <= 1'b1;
         zero_p1   <= (res_p0 == '0);
         parity_p1 <= ^res_p0;
         msb_p1    <= res_p0[WIDTH-1];
         cnt_q     <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else if (out_ready) begin
         vld_p1    <= 1'b0;
      end
   end

   // Clear wins over a same-cycle write; the op itself already saw the old value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
      end else if (acc_clr) begin
         acc_q <= '0;
      end else if (accept_p0 && acc_wr) begin
         acc_q <= res_p0;
      end
   end

   assign result    = res_p1;
   assign out_valid = vld_p1;
   assign zero      = zero_p1;
   assign parity    = parity_p1;
   assign msb       = msb_p1;
   assign acc       = acc_q;
   assign op_count  = cnt_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe at WIDTH=4, CNT_W=16.
module tb_logic_unit_pipe;

   localparam int W = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid, in_ready;
   logic [W-1:0]  a, b;
   logic [2:0]    op;
   logic          use_acc, acc_wr, acc_clr;
   logic          out_valid, out_ready;
   logic [W-1:0]  result;
   logic          zero, parity, msb;
   logic [W-1:0]  acc;
   logic [15:0]   op_count;

   int            vectors = 0;
   int            miscompares = 0;

   logic [W-1:0]  sb[$];
   logic [W-1:0]  m_acc;
   logic [15:0]   m_cnt;
   logic          m_vld;

   logic_unit_pipe #(.WIDTH(W), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .op(op), .use_acc(use_acc), .acc_wr(acc_wr), .acc_clr(acc_clr),
      .out_valid(out_valid), .out_ready(out_ready), .result(result),
      .zero(zero), .parity(parity), .msb(msb), .acc(acc), .op_count(op_count)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   function automatic logic [W-1:0] calc(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      logic [W-1:0] r;
      int sh;
      sh = int'(y[1:0]);
      r  = '0;
      case (o)
         3'd0: r = x & y;
         3'd1: r = x | y;
         3'd2: r = x ^ y;
         3'd3: r = ~(x | y);
         3'd4: for (int i = 0; i < W; i++) if (i + sh < W) r[i+sh] = x[i];
         3'd5: for (int i = 0; i < W; i++) if (i - sh >= 0) r[i-sh] = x[i];
         3'd6: for (int i = 0; i < W; i++) r[(i+sh)%W] = x[i];
         default: r = x & ~y;
      endcase
      return r;
   endfunction

   function automatic logic [W-1:0] sb_pop();
      logic [W-1:0] e;
      e = 'x;
      if (sb.size() > 0) e = sb.pop_front();
      return e;
   endfunction

   task automatic issue(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input bit ua, input bit aw, input bit ac, input bit hold);
      logic [W-1:0] e;
      op = o; a = av; b = bv; use_acc = ua; acc_wr = aw; acc_clr = ac; in_valid = 1'b1;
      if (!m_vld || out_ready) begin
         e = calc(o, ua ? m_acc : av, bv);
         sb.push_back(e);
         m_cnt = m_cnt + 16'd1;
         m_vld = 1'b1;
         if (ac) m_acc = '0;
         else if (aw) m_acc = e;
      end else if (ac) begin
         m_acc = '0;
      end
      @(posedge clk); #1;
      if (!hold) begin
         in_valid = 1'b0; use_acc = 1'b0; acc_wr = 1'b0; acc_clr = 1'b0;
      end
   endtask

   task automatic idle(input bit ac);
      in_valid = 1'b0; acc_clr = ac;
      if (ac) m_acc = '0;
      if (out_ready) m_vld = 1'b0;
      @(posedge clk); #1;
      acc_clr = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; op = '0;
      use_acc = 1'b0; acc_wr = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;
      m_acc = '0; m_cnt = '0; m_vld = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if ({result, zero, parity, msb, acc, op_count, out_valid, in_ready} !== {{W{1'b0}}, 3'b000, {W{1'b0}}, 16'h0, 1'b0, 1'b1}) begin
         miscompares++;
         $display("FAIL reset_state got res=%h z=%b p=%b m=%b acc=%h cnt=%h ov=%b ir=%b want zeros with ir=1",
                  result, zero, parity, msb, acc, op_count, out_valid, in_ready);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_basic_ops();
      logic [W-1:0] e;
      logic [2:0]   ops[5] = '{3'd0, 3'd3, 3'd6, 3'd4, 3'd5};
      logic [W-1:0] as[5]  = '{4'hC, 4'hF, 4'h9, 4'h9, 4'h9};
      logic [W-1:0] bs[5]  = '{4'hA, 4'h0, 4'h1, 4'h1, 4'h3};
      logic [W-1:0] req[5] = '{4'h8, 4'h0, 4'h3, 4'h2, 4'h1};
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         issue(ops[i], as[i], bs[i], 1'b0, 1'b0, 1'b0, 1'b0);
         e = sb_pop();
         vectors++;
         if ({result, zero, parity, msb} !== {e, e == '0, ^e, e[W-1]} || e !== req[i]) begin
            miscompares++;
            $display("FAIL basic_op%0d got res=%h z=%b p=%b m=%b want res=%h z=%b p=%b m=%b",
                     i, result, zero, parity, msb, req[i], req[i] == '0, ^req[i], req[i][W-1]);
         end
         vectors++;
         if ({out_valid, op_count} !== {1'b1, m_cnt}) begin
            miscompares++;
            $display("FAIL basic_state%0d got ov=%b cnt=%h want ov=1 cnt=%h", i, out_valid, op_count, m_cnt);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] e1, e2;
      out_ready = 1'b1;
      idle(1'b0);
      vectors++;
      if (out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL drain_out_valid got %b want 0", out_valid);
      end
      out_ready = 1'b0;
      issue(3'd0, 4'hC, 4'hA, 1'b0, 1'b0, 1'b0, 1'b0);
      e1 = sb_pop();
      issue(3'd2, 4'h5, 4'h3, 1'b0, 1'b0, 1'b0, 1'b1);
      vectors++;
      if ({in_ready, out_valid, result, op_count} !== {1'b0, 1'b1, e1, m_cnt}) begin
         miscompares++;
         $display("FAIL stall_hold got ir=%b ov=%b res=%h cnt=%h want ir=0 ov=1 res=%h cnt=%h",
                  in_ready, out_valid, result, op_count, e1, m_cnt);
      end
      out_ready = 1'b1;
      issue(3'd2, 4'h5, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0);
      e2 = sb_pop();
      vectors++;
      if ({out_valid, result, op_count} !== {1'b1, e2, m_cnt} || e2 !== 4'h6) begin
         miscompares++;
         $display("FAIL release_xor got ov=%b res=%h cnt=%h want ov=1 res=6 cnt=%h", out_valid, result, op_count, m_cnt);
      end
   endtask

   task automatic test_accumulator();
      logic [W-1:0] e;
      logic [W-1:0] bs[4] = '{4'h1, 4'h2, 4'h4, 4'h8};
      out_ready = 1'b1;
      idle(1'b1);
      vectors++;
      if (acc !== 4'h0) begin
         miscompares++;
         $display("FAIL acc_clear got %h want 0", acc);
      end
      for (int i = 0; i < 4; i++) begin
         issue(3'd1, 4'h0, bs[i], 1'b1, 1'b1, i == 3, 1'b0);
         e = sb_pop();
         vectors++;
         if ({result, acc} !== {e, m_acc}) begin
            miscompares++;
            $display("FAIL acc_step%0d got res=%h acc=%h want res=%h acc=%h", i, result, acc, e, m_acc);
         end
         if (i == 2) begin
            vectors++;
            if (acc !== 4'h7) begin
               miscompares++;
               $display("FAIL acc_chain got %h want 7", acc);
            end
         end
      end
      vectors++;
      if ({result, acc} !== {4'hF, 4'h0}) begin
         miscompares++;
         $display("FAIL acc_clr_priority got res=%h acc=%h want res=f acc=0", result, acc);
      end
   endtask

   task automatic test_count_wrap();
      logic [W-1:0] e;
      int n;
      out_ready = 1'b1;
      n = 16'hFFFF - int'(m_cnt);
      op = 3'd0; a = 4'h3; b = 4'h5; use_acc = 1'b0; acc_wr = 1'b0; in_valid = 1'b1;
      repeat (n) @(posedge clk);
      #1;
      in_valid = 1'b0;
      m_cnt = m_cnt + 16'(n);
      m_vld = 1'b1;
      vectors++;
      if ({op_count, result} !== {16'hFFFF, 4'h1}) begin
         miscompares++;
         $display("FAIL count_max got cnt=%h res=%h want cnt=ffff res=1", op_count, result);
      end
      issue(3'd7, 4'hF, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0);
      e = sb_pop();
      vectors++;
      if ({op_count, result} !== {16'h0000, e} || m_cnt !== 16'h0) begin
         miscompares++;
         $display("FAIL count_wrap got cnt=%h res=%h want cnt=0000 res=%h", op_count, result, e);
      end
   endtask

   task automatic test_async_reset();
      out_ready = 1'b1;
      idle(1'b1);
      out_ready = 1'b0;
      issue(3'd1, 4'h0, 4'h7, 1'b1, 1'b1, 1'b0, 1'b0);
      void'(sb_pop());
      vectors++;
      if ({acc, out_valid} !== {4'h7, 1'b1}) begin
         miscompares++;
         $display("FAIL pre_reset got acc=%h ov=%b want acc=7 ov=1", acc, out_valid);
      end
      #3 rst_n = 1'b0;
      #1;
      vectors++;
      if ({result, zero, parity, msb, acc, op_count, out_valid} !== {{W{1'b0}}, 3'b000, {W{1'b0}}, 16'h0, 1'b0}) begin
         miscompares++;
         $display("FAIL async_reset got res=%h z=%b p=%b m=%b acc=%h cnt=%h ov=%b want all 0",
                  result, zero, parity, msb, acc, op_count, out_valid);
      end
      #2 rst_n = 1'b1;
      m_acc = '0; m_cnt = '0; m_vld = 1'b0;
      sb.delete();
      @(posedge clk); #1;
      vectors++;
      if ({in_ready, out_valid} !== 2'b10) begin
         miscompares++;
         $display("FAIL post_reset got ir=%b ov=%b want ir=1 ov=0", in_ready, out_valid);
      end
   endtask

   initial begin
      test_reset();
      test_basic_ops();
      test_back_to_back();
      test_accumulator();
      test_count_wrap();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
